// File: rtl/dm_responder.sv
// -----------------------------------------------------------------------------
// dm_responder
//   Data-memory responder for the MEM-stage load/store initiator. One request is
//   accepted over a valid/ready handshake. Exactly one response pulse follows,
//   WAIT_CYCLES edges after acceptance. Word, half and byte stores are merged
//   into the addressed word. Loads are sign- or zero-extended. Misaligned,
//   out-of-range and reserved-width requests complete with rsp_err set.
//
// Parameters
//   ADDR_W       word-address width (depth = 2**ADDR_W 32-bit words)
//   WAIT_CYCLES  extra cycles between acceptance and response (0..15)
//   BASE_ADDR    byte address of word 0 (word aligned)
//
// Ports
//   clk        clock; all state changes on the rising edge
//   reset      asynchronous reset, active low
//   req_*      request channel (valid/ready, we, width, sign, addr, wdata, pc)
//   rsp_valid  one-cycle completion pulse
//   rsp_rdata  extended load data; 0 for stores and errors (held between pulses)
//   rsp_err    error flag qualified by rsp_valid (held between pulses)
//   busy       high from the accept edge until the edge that raises rsp_valid
//
// Build option
//   DM_TRACE_EN  when defined, every committed store prints one trace line that
//                shows pc, word byte address and merged word. When undefined,
//                req_pc is unused.
// -----------------------------------------------------------------------------
module dm_responder #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_width,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned DEPTH     = 2 ** ADDR_W;
    localparam logic [32:0] MEM_BYTES = 33'(1) << (ADDR_W + 2);
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] W_WORD = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_BYTE = 2'b10;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, sign_q;
    logic [1:0]  width_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem [DEPTH];

    logic        accept, commit, use_live;
    logic        op_we, op_sign;
    logic [1:0]  op_width;
    logic [31:0] op_addr, op_wdata;
    logic [31:0] off;
    logic [1:0]  lane;
    logic [ADDR_W-1:0] idx;
    logic        misalign, op_err;
    logic [31:0] cur_word, merged, field, load_val;

    assign req_ready = (state_q != S_WAIT);
    assign accept    = req_valid & req_ready;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign busy      = (state_q == S_WAIT);

    // Work is done on the edge that enters RESP. With no wait states, that edge is
    // the accept edge itself, so the live request fields are used instead of the
    // latched copy.
    assign commit   = ((state_q == S_WAIT) && (cnt_q == 4'd0)) ||
                      (accept && (WAIT_CYCLES == 0));
    assign use_live = (state_q != S_WAIT);

    assign op_we    = use_live ? req_we    : we_q;
    assign op_width = use_live ? req_width : width_q;
    assign op_sign  = use_live ? req_sign  : sign_q;
    assign op_addr  = use_live ? req_addr  : addr_q;
    assign op_wdata = use_live ? req_wdata : wdata_q;

    assign off      = op_addr - BASE_ADDR;
    assign lane     = off[1:0];
    assign idx      = off[ADDR_W+1:2];
    assign cur_word = mem[idx];

    always_comb begin
        misalign = 1'b0;
        unique case (op_width)
            W_WORD:  misalign = (lane != 2'b00);
            W_HALF:  misalign = lane[0];
            default: misalign = 1'b0;
        endcase
    end

    assign op_err = (op_width == 2'b11) || misalign || (op_addr < BASE_ADDR) ||
                    ({1'b0, off} >= MEM_BYTES);

    always_comb begin
        merged = cur_word;
        unique case (op_width)
            W_WORD:  merged = op_wdata;
            W_HALF:  merged[{lane[1], 4'b0000} +: 16] = op_wdata[15:0];
            W_BYTE:  merged[{lane, 3'b000} +: 8] = op_wdata[7:0];
            default: merged = cur_word;
        endcase
    end

    assign field = cur_word >> {lane, 3'b000};

    always_comb begin
        load_val = cur_word;
        unique case (op_width)
            W_HALF:  load_val = {{16{op_sign & field[15]}}, field[15:0]};
            W_BYTE:  load_val = {{24{op_sign & field[7]}}, field[7:0]};
            default: load_val = cur_word;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    cnt_d   = WAIT_INIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = 4'(cnt_q - 4'd1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            width_q <= 2'b00;
            sign_q  <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                width_q <= req_width;
                sign_q  <= req_sign;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (commit) begin
                rdata_q <= (op_err || op_we) ? 32'h0 : load_val;
                err_q   <= op_err;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (commit && op_we && !op_err) begin
            mem[idx] <= merged;
        end
    end

`ifdef DM_TRACE_EN
    logic [31:0] pc_q;
    logic [31:0] op_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= 32'h0;
        end else if (accept) begin
            pc_q <= req_pc;
        end
    end

    assign op_pc = use_live ? req_pc : pc_q;

    always @(posedge clk) begin
        if (reset && commit && op_we && !op_err) begin
            $display("%d@%h: *%h <= %h", $time, op_pc, BASE_ADDR + 32'({idx, 2'b00}), merged);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder. It drives two instances: u_dut0 (2 wait states, base 0) and
// u_dut1 (no wait states, base 0x1000). Both are compared against a byte-array model.
module tb_dm_responder;

    localparam int unsigned AW = 6;
    localparam int unsigned MEMB = 4 * (2 ** AW);
    localparam logic [31:0] BASE1 = 32'h1000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_width = 2'b00;
    logic        req_sign = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [31:0] req_pc = 32'h0;

    logic        ready0, ready1, rv0, rv1, err0, err1, busy0, busy1;
    logic [31:0] rd0, rd1;
    logic        ready, rv, rerr;
    logic [31:0] rd;

    int nerr = 0;
    int nchecks = 0;
    logic [31:0] last_rd;
    logic        last_err;

    logic [7:0] mb [2][MEMB];

    always #5 clk = ~clk;

    dm_responder #(.ADDR_W(AW), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(ready0),
        .req_we(req_we), .req_width(req_width), .req_sign(req_sign), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_pc(req_pc), .rsp_valid(rv0), .rsp_rdata(rd0),
        .rsp_err(err0), .busy(busy0)
    );

    dm_responder #(.ADDR_W(AW), .WAIT_CYCLES(0), .BASE_ADDR(BASE1)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(ready1),
        .req_we(req_we), .req_width(req_width), .req_sign(req_sign), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_pc(req_pc), .rsp_valid(rv1), .rsp_rdata(rd1),
        .rsp_err(err1), .busy(busy1)
    );

    assign ready = sel ? ready1 : ready0;
    assign rv    = sel ? rv1 : rv0;
    assign rd    = sel ? rd1 : rd0;
    assign rerr  = sel ? err1 : err0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: byte-addressed little-endian memory with access rules applied
    // directly to the byte offset.
    function automatic void model(input bit d, input logic we, input logic [1:0] w,
                                  input logic s, input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] er, output logic ee);
        logic [31:0] base, off, v, mask;
        int n;
        base = d ? BASE1 : 32'h0;
        n    = (w == 2'd0) ? 4 : (w == 2'd1) ? 2 : 1;
        off  = a - base;
        er   = 32'h0;
        ee   = (w == 2'd3) || (a < base) || (off >= MEMB) || ((off % n) != 0);
        if (ee) return;
        if (we) begin
            for (int k = 0; k < n; k++) mb[d][off+k] = wd[8*k +: 8];
        end else begin
            v = 32'h0;
            for (int k = 0; k < n; k++) v |= 32'(mb[d][off+k]) << (8 * k);
            mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
            if (s && v[8*n-1]) v |= ~mask;
            er = v;
        end
    endfunction

    task automatic drive(input logic we, input logic [1:0] w, input logic s,
                         input logic [31:0] a, input logic [31:0] wd);
        req_we = we; req_width = w; req_sign = s; req_addr = a; req_wdata = wd;
        req_pc = $urandom;
        req_valid = 1'b1;
    endtask

    // One complete transaction; latency, data, error and pulse width are checked.
    task automatic req(input bit d, input logic we, input logic [1:0] w, input logic s,
                       input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] er;
        logic        ee;
        int          n;
        @(negedge clk);
        sel = d;
        drive(we, w, s, a, wd);
        check("ready_idle", 32'(ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (!d) check("busy_wait", 32'(busy0), 32'd1);
        n = 0;
        while (!rv && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), d ? 32'd0 : 32'd2);
        model(d, we, w, s, a, wd, er, ee);
        last_rd  = rd;
        last_err = rerr;
        check("rdata", rd, er);
        check("err", 32'(rerr), 32'(ee));
        if (!d) check("busy_resp", 32'(busy0), 32'd0);
        @(negedge clk);
        check("pulse_end", 32'(rv), 32'd0);
        check("rdata_hold", rd, er);
    endtask

    initial begin
        logic [31:0] er, base, off;
        logic        ee;
        bit          d;
        logic [1:0]  w;
        int          n;
        for (int b = 0; b < 2; b++) for (int i = 0; i < MEMB; i++) mb[b][i] = 8'h00;

        repeat (2) @(negedge clk);
        check("rst_ready0", 32'(ready0), 32'd1);
        check("rst_ready1", 32'(ready1), 32'd1);
        check("rst_rv", {30'd0, rv0, rv1}, 32'd0);
        check("rst_rdata", rd0 | rd1, 32'd0);
        check("rst_err_busy", {30'd0, err0 | err1, busy0 | busy1}, 32'd0);
        reset = 1'b1;

        // Reset in the middle of a store's wait: no response and no write.
        @(negedge clk);
        sel = 1'b0;
        drive(1'b1, 2'b00, 1'b0, 32'h0, 32'h1122_3344);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_mid_rv", 32'(rv0), 32'd0);
        end
        check("rst_mid_busy", 32'(busy0), 32'd0);
        reset = 1'b1;
        req(0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        check("rst_no_write", last_rd, 32'h0);

        // Store word, merge a byte, extended loads.
        req(0, 1'b1, 2'b00, 1'b0, 32'h10, 32'hDEAD_BEEF);
        req(0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        check("ld_word", last_rd, 32'hDEAD_BEEF);
        req(0, 1'b1, 2'b10, 1'b0, 32'h13, 32'h0000_0080);
        req(0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        check("byte_merge", last_rd, 32'h80AD_BEEF);
        req(0, 1'b0, 2'b10, 1'b1, 32'h13, 32'h0);
        check("ld_byte_s", last_rd, 32'hFFFF_FF80);
        req(0, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
        check("ld_byte_u", last_rd, 32'h0000_0080);

        // Error cases.
        req(0, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
        check("half_misalign", {31'd0, last_err}, 32'd1);
        req(0, 1'b1, 2'b00, 1'b0, 32'h12, 32'hCAFE_F00D);
        check("word_misalign", {31'd0, last_err}, 32'd1);
        req(0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        check("no_err_write", last_rd, 32'h80AD_BEEF);
        req(0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        check("width_rsvd", {31'd0, last_err}, 32'd1);
        req(0, 1'b0, 2'b00, 1'b0, 32'(MEMB), 32'h0);
        check("range0", {31'd0, last_err}, 32'd1);
        req(1, 1'b0, 2'b00, 1'b0, BASE1 + 32'(MEMB), 32'h0);
        check("range1", {31'd0, last_err}, 32'd1);
        req(1, 1'b0, 2'b00, 1'b0, BASE1 - 32'd4, 32'h0);
        check("below_base", {31'd0, last_err}, 32'd1);

        // Back-to-back loads with no wait states.
        for (int i = 0; i < 4; i++)
            req(1, 1'b1, 2'b00, 1'b0, BASE1 + 32'(4 * i), $urandom);
        @(negedge clk);
        sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'b00, 1'b0, BASE1 + 32'(4 * i), 32'h0);
            check("b2b_ready", 32'(ready1), 32'd1);
            @(negedge clk);
            model(1'b1, 1'b0, 2'b00, 1'b0, BASE1 + 32'(4 * i), 32'h0, er, ee);
            check("b2b_rv", 32'(rv1), 32'd1);
            check("b2b_rdata", rd1, er);
        end
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b_end", 32'(rv1), 32'd0);

        // Randomized traffic on both instances.
        for (int i = 0; i < 160; i++) begin
            d    = 1'($urandom);
            w    = 2'($urandom);
            base = d ? BASE1 : 32'h0;
            off  = $urandom % (MEMB + 8);
            n    = (w == 2'd0) ? 4 : (w == 2'd1) ? 2 : 1;
            if ($urandom % 4 != 0) off = off & ~32'(n - 1);
            if (d && ($urandom % 10 == 0)) off = -32'($urandom_range(1, 8));
            req(d, 1'($urandom), w, 1'($urandom), base + off, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
